// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, screen limits and per-stage start positions for stage_sequencer
package game_pkg;
  typedef enum logic [2:0] {
    TITLE = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    HIT   = 3'd4,
    CLEAR = 3'd5,
    OVER  = 3'd6,
    WIN   = 3'd7
  } state_t;
  localparam int MAX_STAGES   = 16;
  localparam int SCREEN_H_MAX = 319;
  localparam int SCREEN_V_MAX = 239;
  localparam int POS_MIN      = 20;
  typedef struct packed {
    logic [9:0] h_cy;
    logic [9:0] v_cy;
    logic [9:0] h_mon;
    logic [9:0] v_mon;
  } pos_t;
  localparam pos_t [0:MAX_STAGES-1] INIT_TAB = {
    {10'd20,  10'd20,  10'd300, 10'd220},
    {10'd36,  10'd28,  10'd284, 10'd212},
    {10'd52,  10'd36,  10'd268, 10'd204},
    {10'd68,  10'd44,  10'd252, 10'd196},
    {10'd84,  10'd52,  10'd236, 10'd188},
    {10'd100, 10'd60,  10'd220, 10'd180},
    {10'd116, 10'd68,  10'd204, 10'd172},
    {10'd132, 10'd76,  10'd188, 10'd164},
    {10'd148, 10'd84,  10'd172, 10'd156},
    {10'd164, 10'd92,  10'd156, 10'd148},
    {10'd180, 10'd100, 10'd140, 10'd140},
    {10'd196, 10'd108, 10'd124, 10'd132},
    {10'd212, 10'd116, 10'd108, 10'd124},
    {10'd228, 10'd124, 10'd92,  10'd116},
    {10'd244, 10'd132, 10'd76,  10'd108},
    {10'd260, 10'd140, 10'd60,  10'd100}
  };
endpackage

// File: rtl/stage_init_rom.sv
// stage_init_rom: combinational lookup of player/monster start positions for a stage
module stage_init_rom
  import game_pkg::*;
(
  input  logic [3:0] stage,
  output pos_t       pos
);
  assign pos = INIT_TAB[stage];
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: game-flow FSM (title/load/play/pause/hit/clear/over/win); INVINCIBLE_FRAMES_EN adds post-respawn immunity
module stage_sequencer
  import game_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int LIVES_INIT   = 3,
  parameter int HIT_TICKS    = 30,
  parameter int IFRAME_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPACE_signal,
  input  logic       frame_tick,
  input  logic       collide,
  input  logic       goal,
  output logic [2:0] state,
  output logic [3:0] stage,
  output logic [1:0] lives,
  output logic       load,
  output logic       move_en,
  output logic       invuln,
  output logic [9:0] init_pos_h_CY,
  output logic [9:0] init_pos_v_CY,
  output logic [9:0] init_pos_h_mon,
  output logic [9:0] init_pos_v_mon
);
  state_t      state_q, state_n;
  logic [3:0]  stage_n;
  logic [1:0]  lives_n;
  logic [15:0] hit_cnt;
  logic        space_d, space_rise, hit_done;
  pos_t        rom_pos, pos_q;
  stage_init_rom u_rom (.stage(stage_n), .pos(rom_pos));
  assign space_rise     = SPACE_signal & ~space_d;
  assign hit_done       = frame_tick && hit_cnt == 16'(HIT_TICKS - 1);
  assign state          = state_q;
  assign load           = state_q == LOAD;
  assign move_en        = state_q == PLAY;
  assign init_pos_h_CY  = pos_q.h_cy;
  assign init_pos_v_CY  = pos_q.v_cy;
  assign init_pos_h_mon = pos_q.h_mon;
  assign init_pos_v_mon = pos_q.v_mon;
  // next state, stage and lives decisions
  always_comb begin
    state_n = state_q;
    stage_n = stage;
    lives_n = lives;
    case (state_q)
      TITLE: state_n = space_rise ? LOAD : TITLE;
      LOAD:  state_n = PLAY;
      PLAY:
        if (collide && !invuln) begin
          state_n = HIT;
          lives_n = lives == 2'd0 ? 2'd0 : lives - 2'd1;
        end else if (goal) state_n = CLEAR;
        else if (space_rise) state_n = PAUSE;
      PAUSE: state_n = space_rise ? PLAY : PAUSE;
      HIT:   if (hit_done) state_n = lives == 2'd0 ? OVER : LOAD;
      CLEAR:
        if (space_rise) begin
          if (stage == 4'(NUM_STAGES - 1)) state_n = WIN;
          else begin
            state_n = LOAD;
            stage_n = stage + 4'd1;
          end
        end
      default:
        if (space_rise) begin
          state_n = TITLE;
          stage_n = 4'd0;
          lives_n = 2'(LIVES_INIT);
        end
    endcase
  end
  // state, progress, hit timer and start-position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TITLE;
      stage   <= 4'd0;
      lives   <= 2'(LIVES_INIT);
      space_d <= 1'b1;
      hit_cnt <= 16'd0;
      pos_q   <= INIT_TAB[0];
    end else begin
      state_q <= state_n;
      stage   <= stage_n;
      lives   <= lives_n;
      space_d <= SPACE_signal;
      hit_cnt <= state_q != HIT ? 16'd0 : frame_tick ? hit_cnt + 16'd1 : hit_cnt;
      pos_q   <= rom_pos;
    end
  end
`ifdef INVINCIBLE_FRAMES_EN
  logic [15:0] iframe_cnt;
  // immunity window armed on respawn, counted down only while playing
  always_ff @(posedge clk) begin
    if (rst) begin
      invuln     <= 1'b0;
      iframe_cnt <= 16'd0;
    end else if (state_n == LOAD) begin
      invuln     <= state_q == HIT;
      iframe_cnt <= 16'd0;
    end else if (state_q == PLAY && invuln && frame_tick) begin
      invuln     <= iframe_cnt != 16'(IFRAME_TICKS - 1);
      iframe_cnt <= iframe_cnt + 16'd1;
    end
  end
`else
  assign invuln = IFRAME_TICKS < 0;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: scoreboard bench for stage_sequencer in the default build
module tb_stage_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic       SPACE_signal = 1'b1, frame_tick = 1'b0, collide = 1'b0, goal = 1'b0;
  logic [2:0] state;
  logic [3:0] stage;
  logic [1:0] lives;
  logic       load, move_en, invuln;
  logic [9:0] init_pos_h_CY, init_pos_v_CY, init_pos_h_mon, init_pos_v_mon;
  int total = 0, bad = 0;
  localparam int T = 0, L = 1, P = 2, PS = 3, H = 4, C = 5, O = 6, W = 7;
  typedef struct {
    string tag;
    int    st;
    int    stg;
    int    lv;
  } exp_t;
  exp_t exp_q[$];
  stage_sequencer dut (
    .clk(clk), .rst(rst), .SPACE_signal(SPACE_signal), .frame_tick(frame_tick),
    .collide(collide), .goal(goal), .state(state), .stage(stage), .lives(lives),
    .load(load), .move_en(move_en), .invuln(invuln),
    .init_pos_h_CY(init_pos_h_CY), .init_pos_v_CY(init_pos_v_CY),
    .init_pos_h_mon(init_pos_h_mon), .init_pos_v_mon(init_pos_v_mon)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic step(string tag, logic sp, logic ft, logic col, logic gl, int st, int stg, int lv);
    exp_t e;
    exp_q.push_back('{tag, st, stg, lv});
    SPACE_signal = sp;
    frame_tick   = ft;
    collide      = col;
    goal         = gl;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".state"}, state, e.st);
    check({e.tag, ".stage"}, stage, e.stg);
    check({e.tag, ".lives"}, lives, e.lv);
    check({e.tag, ".move_en"}, move_en, e.st == P);
    check({e.tag, ".load"}, load, e.st == L);
    check({e.tag, ".invuln"}, invuln, 0);
  endtask
  task automatic check_pos(int s);
    check("pos_h_cy", init_pos_h_CY, 20 + 16 * s);
    check("pos_v_cy", init_pos_v_CY, 20 + 8 * s);
    check("pos_h_mon", init_pos_h_mon, 300 - 16 * s);
    check("pos_v_mon", init_pos_v_mon, 220 - 8 * s);
  endtask
  task automatic hit(int lv_after, int after_st);
    step("hit", 0, 0, 1, 1, H, 0, lv_after);
    for (int i = 0; i < 29; i++) step("hit_wait", 0, 1, 0, 0, H, 0, lv_after);
    step("hit_end", 0, 1, 0, 0, after_st, 0, lv_after);
  endtask
  initial begin
    step("rst", 1, 0, 0, 0, T, 0, 3);
    step("rst", 1, 0, 0, 0, T, 0, 3);
    rst = 1'b0;
    step("held", 1, 0, 0, 0, T, 0, 3);
    step("held", 1, 0, 0, 0, T, 0, 3);
    check_pos(0);
    step("release", 0, 0, 0, 0, T, 0, 3);
    step("start", 1, 0, 0, 0, L, 0, 3);
    check_pos(0);
    step("play", 0, 0, 0, 0, P, 0, 3);
    hit(2, L);
    step("respawn", 0, 0, 0, 0, P, 0, 2);
    hit(1, L);
    step("respawn", 0, 0, 0, 0, P, 0, 1);
    hit(0, O);
    step("over_idle", 0, 1, 0, 0, O, 0, 0);
    step("over_space", 1, 0, 0, 0, T, 0, 3);
    step("title", 0, 0, 0, 0, T, 0, 3);
    step("start2", 1, 0, 0, 0, L, 0, 3);
    step("play2", 0, 0, 0, 0, P, 0, 3);
    for (int s = 0; s < 3; s++) begin
      step("goal", 0, 0, 0, 1, C, s, 3);
      step("clear_idle", 0, 1, 0, 1, C, s, 3);
      step("next", 1, 0, 0, 0, L, s + 1, 3);
      check_pos(s + 1);
      step("play_next", 0, 0, 0, 0, P, s + 1, 3);
    end
    step("goal_last", 0, 0, 0, 1, C, 3, 3);
    step("win", 1, 0, 0, 0, W, 3, 3);
    step("win_idle", 0, 0, 0, 0, W, 3, 3);
    step("win_space", 1, 0, 0, 0, T, 0, 3);
    check_pos(0);
    step("title2", 0, 0, 0, 0, T, 0, 3);
    step("start3", 1, 0, 0, 0, L, 0, 3);
    step("play3", 0, 0, 0, 0, P, 0, 3);
    step("pause", 1, 0, 0, 0, PS, 0, 3);
    step("pause_rel", 0, 0, 0, 0, PS, 0, 3);
    for (int i = 0; i < 3; i++) step("pause_col", 0, 1, 1, 0, PS, 0, 3);
    step("pause_goal", 0, 1, 0, 1, PS, 0, 3);
    step("resume", 1, 0, 0, 0, P, 0, 3);
    step("resume_rel", 0, 0, 0, 0, P, 0, 3);
    step("hit_mid", 0, 0, 1, 0, H, 0, 2);
    step("hit_tick", 0, 1, 0, 0, H, 0, 2);
    rst = 1'b1;
    step("rst_mid", 1, 1, 0, 0, T, 0, 3);
    rst = 1'b0;
    step("rst_held", 1, 0, 0, 0, T, 0, 3);
    step("rst_rel", 0, 0, 0, 0, T, 0, 3);
    step("rst_press", 1, 0, 0, 0, L, 0, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
